// File: rtl/spi_pwm_array.sv
// SPI-programmed PWM array: NUM_CH channels with double-buffered duty, shared period and prescaler.
// SPI pins are synchronised into clk; frames commit on the chip-select rising edge.
module spi_pwm_array #(
  parameter int unsigned NUM_CH    = 16,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned PRESC_W   = 8,
  parameter int unsigned PRESC_RST = 0,
  parameter int unsigned SYNC_STG  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              copi,
  input  logic              ncs,
  output logic [NUM_CH-1:0] out_en,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_wrap,
  output logic              frame_err
);

  localparam int unsigned CntBytes = (CNT_W + 7) / 8;
  localparam int unsigned CntPadW  = CntBytes * 8;
  localparam int unsigned PscBytes = (PRESC_W + 7) / 8;
  localparam int unsigned PscPadW  = PscBytes * 8;

  // Reset asserts asynchronously and releases synchronously to clk.
  logic [1:0] rst_sync_q;
  logic       rst_core_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_core_n = rst_sync_q[1];

  // SPI input synchronisers and edge detection
  logic [SYNC_STG-1:0] sclk_sync_q, copi_sync_q, ncs_sync_q;
  logic                sclk_prev_q, ncs_prev_q;
  logic                sclk_s, copi_s, ncs_s;
  logic                sclk_rise, ncs_rise, ncs_fall;

  // ncs resets to 0 so a select held low across reset never produces a frame.
  always_ff @(posedge clk or negedge rst_core_n) begin
    if (!rst_core_n) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      ncs_prev_q  <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STG-2:0], sclk};
      copi_sync_q <= {copi_sync_q[SYNC_STG-2:0], copi};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STG-2:0], ncs};
      sclk_prev_q <= sclk_s;
      ncs_prev_q  <= ncs_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STG-1];
  assign copi_s    = copi_sync_q[SYNC_STG-1];
  assign ncs_s     = ncs_sync_q[SYNC_STG-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign ncs_rise  = ncs_s & ~ncs_prev_q;
  assign ncs_fall  = ~ncs_s & ncs_prev_q;

  // Frame receiver
  logic        active_q, active_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] shift_q, shift_d;
  logic        wr_req_q, wr_req_d;
  logic [6:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        frame_err_q, frame_err_d;

  always_comb begin
    active_d    = active_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    wr_req_d    = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_err_d = 1'b0;
    if (ncs_fall) begin
      active_d  = 1'b1;
      bit_cnt_d = 5'd0;
    end else if (active_q && ncs_rise) begin
      active_d  = 1'b0;
      bit_cnt_d = 5'd0;
      if (bit_cnt_q == 5'd16) begin
        wr_req_d  = shift_q[15];
        wr_addr_d = shift_q[14:8];
        wr_data_d = shift_q[7:0];
      end else begin
        frame_err_d = 1'b1;
      end
    end else if (active_q && !ncs_s && sclk_rise) begin
      shift_d = {shift_q[14:0], copi_s};
      if (bit_cnt_q != 5'd17) bit_cnt_d = bit_cnt_q + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_core_n) begin
    if (!rst_core_n) begin
      active_q    <= 1'b0;
      bit_cnt_q   <= 5'd0;
      shift_q     <= 16'h0000;
      wr_req_q    <= 1'b0;
      wr_addr_q   <= 7'h00;
      wr_data_q   <= 8'h00;
      frame_err_q <= 1'b0;
    end else begin
      active_q    <= active_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      wr_req_q    <= wr_req_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Register file
  logic [NUM_CH-1:0]            en_out_q, en_out_d;
  logic [NUM_CH-1:0]            en_pwm_q, en_pwm_d;
  logic [CNT_W-1:0]             period_q, period_d;
  logic [PRESC_W-1:0]           presc_q, presc_d;
  logic [NUM_CH-1:0][CNT_W-1:0] duty_pend_q, duty_pend_d;
  logic [CntPadW-1:0]           period_pad;
  logic [PscPadW-1:0]           presc_pad;

  always_comb begin
    en_out_d    = en_out_q;
    en_pwm_d    = en_pwm_q;
    duty_pend_d = duty_pend_q;
    period_pad  = CntPadW'(period_q);
    presc_pad   = PscPadW'(presc_q);
    if (wr_req_q) begin
      for (int k = 0; k < int'(NUM_CH / 8) && k < 4; k++) begin
        if (wr_addr_q == 7'(k))     en_out_d[8*k +: 8] = wr_data_q;
        if (wr_addr_q == 7'(4 + k)) en_pwm_d[8*k +: 8] = wr_data_q;
      end
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (wr_addr_q == 7'(16 + i)) duty_pend_d[i] = CNT_W'(wr_data_q);
      end
      // Byte 0 sits at 0x08/0x09; upper bytes live at 0x0A/0x0B and 0x0C/0x0D.
      for (int b = 0; b < int'(CntBytes) && b < 3; b++) begin
        if (wr_addr_q == ((b == 0) ? 7'h08 : 7'(9 + b))) period_pad[8*b +: 8] = wr_data_q;
      end
      for (int b = 0; b < int'(PscBytes) && b < 3; b++) begin
        if (wr_addr_q == ((b == 0) ? 7'h09 : 7'(11 + b))) presc_pad[8*b +: 8] = wr_data_q;
      end
    end
    period_d = period_pad[CNT_W-1:0];
    presc_d  = presc_pad[PRESC_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_core_n) begin
    if (!rst_core_n) begin
      en_out_q    <= '0;
      en_pwm_q    <= '0;
      period_q    <= '1;
      presc_q     <= PRESC_W'(PRESC_RST);
      duty_pend_q <= '0;
    end else begin
      en_out_q    <= en_out_d;
      en_pwm_q    <= en_pwm_d;
      period_q    <= period_d;
      presc_q     <= presc_d;
      duty_pend_q <= duty_pend_d;
    end
  end

  // Timebase; >= comparisons let a shrunken PERIOD/PRESCALE wrap on the next tick.
  logic [PRESC_W-1:0]           presc_cnt_q, presc_cnt_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [NUM_CH-1:0][CNT_W-1:0] duty_act_q, duty_act_d;
  logic                         tick, wrap;

  always_comb begin
    tick        = (presc_cnt_q >= presc_q);
    wrap        = tick && (cnt_q >= period_q);
    presc_cnt_d = tick ? '0 : presc_cnt_q + 1'b1;
    cnt_d       = cnt_q;
    if (tick) cnt_d = wrap ? '0 : cnt_q + 1'b1;
    duty_act_d  = wrap ? duty_pend_q : duty_act_q;
  end

  // Registered outputs
  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic [NUM_CH-1:0] out_en_q;
  logic              wrap_q;

  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      pwm_d[i] = en_out_q[i] & (en_pwm_q[i] ? (cnt_q < duty_act_q[i]) : 1'b1);
    end
  end

  always_ff @(posedge clk or negedge rst_core_n) begin
    if (!rst_core_n) begin
      presc_cnt_q <= '0;
      cnt_q       <= '0;
      duty_act_q  <= '0;
      pwm_q       <= '0;
      out_en_q    <= '0;
      wrap_q      <= 1'b0;
    end else begin
      presc_cnt_q <= presc_cnt_d;
      cnt_q       <= cnt_d;
      duty_act_q  <= duty_act_d;
      pwm_q       <= pwm_d;
      out_en_q    <= en_out_q;
      wrap_q      <= wrap;
    end
  end

  assign out_en      = out_en_q;
  assign pwm_out     = pwm_q;
  assign period_wrap = wrap_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_pwm_array.sv
// Directed bench for spi_pwm_array: SPI writes, wrap intervals, per-period duty counts, frame errors.
module tb_spi_pwm_array;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        sclk = 1'b0;
  logic        copi = 1'b0;
  logic        ncs = 1'b1;
  logic [15:0] out_en;
  logic [15:0] pwm_out;
  logic        period_wrap;
  logic        frame_err;

  int checks = 0;
  int failures = 0;

  spi_pwm_array dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sclk       (sclk),
    .copi       (copi),
    .ncs        (ncs),
    .out_en     (out_en),
    .pwm_out    (pwm_out),
    .period_wrap(period_wrap),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  // Per-period observers: window is (previous wrap sample, this wrap sample].
  int cyc = 0;
  int err_cnt = 0;
  int hi_acc[16];
  int hi_last[16];
  int rise_acc = 0;
  int rise_last = 0;
  logic p0_prev = 1'b0;

  initial begin
    for (int i = 0; i < 16; i++) begin
      hi_acc[i]  = 0;
      hi_last[i] = 0;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    err_cnt <= err_cnt + int'(frame_err === 1'b1);
    p0_prev <= pwm_out[0];
    for (int i = 0; i < 16; i++) begin
      hi_acc[i] <= period_wrap ? 0 : hi_acc[i] + int'(pwm_out[i] === 1'b1);
      if (period_wrap) hi_last[i] <= hi_acc[i] + int'(pwm_out[i] === 1'b1);
    end
    rise_acc <= period_wrap ? 0 : rise_acc + int'(pwm_out[0] && !p0_prev);
    if (period_wrap) rise_last <= rise_acc + int'(pwm_out[0] && !p0_prev);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b);
    copi = b;
    clks(3);
    sclk = 1'b1;
    clks(3);
    sclk = 1'b0;
  endtask

  task automatic spi_frame(input logic [31:0] v, input int n);
    ncs = 1'b0;
    clks(3);
    for (int i = n - 1; i >= 0; i--) spi_bit(v[i]);
    clks(3);
    ncs = 1'b1;
    clks(6);
    #1;
  endtask

  task automatic spi_wr(input logic [6:0] a, input logic [7:0] d);
    spi_frame({16'h0000, 1'b1, a, d}, 16);
  endtask

  task automatic wait_wrap(input string tag, output int c);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (period_wrap !== 1'b1 && n < 3000);
    checks++;
    assert (period_wrap === 1'b1) else begin
      failures++;
      $error("FAIL %s_timeout observed=%b expected=1", tag, period_wrap);
    end
    c = cyc;
    #1;
  endtask

  int c1, c2, e0;

  initial begin
    // T1: reset held while SPI pins toggle
    #1 rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      clks(1);
      sclk = ~sclk;
      copi = i[0];
      ncs  = i[1];
    end
    #1;
    chk("rst_out_en", 32'(out_en), 32'h0);
    chk("rst_pwm_out", 32'(pwm_out), 32'h0);
    chk("rst_period_wrap", 32'(period_wrap), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    sclk = 1'b0;
    copi = 1'b0;
    ncs  = 1'b1;
    clks(1);
    rst_n = 1'b1;
    wait_wrap("t1_w1", c1);
    wait_wrap("t1_w2", c2);
    chk("t1_wrap_interval", 32'(c2 - c1), 32'd256);
    chk("t1_no_frame_err", 32'(err_cnt), 32'd0);

    // T2: enable byte 0, PWM on ch0 at 50%
    spi_wr(7'h00, 8'hFF);
    spi_wr(7'h04, 8'h01);
    spi_wr(7'h10, 8'h80);
    spi_wr(7'h09, 8'h00);
    wait_wrap("t2_w1", c1);
    wait_wrap("t2_w2", c2);
    chk("t2_ch0_high", 32'(hi_last[0]), 32'd128);
    chk("t2_ch0_rises", 32'(rise_last), 32'd1);
    for (int i = 1; i < 8; i++) chk($sformatf("t2_ch%0d_const_high", i), 32'(hi_last[i]), 32'd256);
    chk("t2_ch8_low", 32'(hi_last[8]), 32'd0);
    chk("t2_out_en", 32'(out_en), 32'h00FF);

    // T3: duty change mid-period applies from the following period
    spi_wr(7'h10, 8'h40);
    wait_wrap("t3_w1", c1);
    chk("t3_cur_period_high", 32'(hi_last[0]), 32'd128);
    wait_wrap("t3_w2", c2);
    chk("t3_next_period_high", 32'(hi_last[0]), 32'd64);
    chk("t3_rises", 32'(rise_last), 32'd1);

    // T4: short period with prescaler, duty beyond period and zero duty
    spi_wr(7'h04, 8'h0D);
    spi_wr(7'h08, 8'h09);
    spi_wr(7'h13, 8'h0C);
    spi_wr(7'h12, 8'h00);
    spi_wr(7'h09, 8'h03);
    wait_wrap("t4_w0", c1);
    wait_wrap("t4_w1", c1);
    wait_wrap("t4_w2", c2);
    chk("t4_wrap_interval", 32'(c2 - c1), 32'd40);
    chk("t4_ch3_const_high", 32'(hi_last[3]), 32'd40);
    chk("t4_ch2_const_low", 32'(hi_last[2]), 32'd0);
    chk("t4_ch0_duty_gt_period", 32'(hi_last[0]), 32'd40);
    chk("t4_ch1_no_pwm", 32'(hi_last[1]), 32'd40);

    // T5: malformed frames, read frame, unmapped address
    e0 = err_cnt;
    spi_frame(32'h0000_9003 >> 1, 15);
    spi_frame(32'h0001_2006, 17);
    spi_frame(32'h0, 0);
    chk("t5_frame_err_count", 32'(err_cnt - e0), 32'd3);
    spi_frame(32'h0000_1003, 16);
    spi_wr(7'h7F, 8'h03);
    chk("t5_no_extra_err", 32'(err_cnt - e0), 32'd3);
    wait_wrap("t5_w1", c1);
    wait_wrap("t5_w2", c2);
    chk("t5_ch0_duty_kept", 32'(hi_last[0]), 32'd40);
    chk("t5_ch2_duty_kept", 32'(hi_last[2]), 32'd0);
    chk("t5_out_en_kept", 32'(out_en), 32'h00FF);
    chk("t5_wrap_interval", 32'(c2 - c1), 32'd40);

    // T6: reset in the middle of a frame
    e0 = err_cnt;
    ncs = 1'b0;
    clks(3);
    for (int i = 0; i < 9; i++) spi_bit(i[0]);
    rst_n = 1'b0;
    clks(3);
    #1;
    chk("t6_rst_out_en", 32'(out_en), 32'h0);
    chk("t6_rst_pwm_out", 32'(pwm_out), 32'h0);
    rst_n = 1'b1;
    clks(5);
    ncs = 1'b1;
    clks(6);
    #1;
    chk("t6_partial_no_err", 32'(err_cnt - e0), 32'd0);
    chk("t6_regs_reset", 32'(out_en), 32'h0);
    spi_wr(7'h00, 8'h0F);
    chk("t6_out_en", 32'(out_en), 32'h000F);
    chk("t6_pwm_out", 32'(pwm_out), 32'h000F);
    chk("t6_no_err", 32'(err_cnt - e0), 32'd0);
    wait_wrap("t6_w1", c1);
    wait_wrap("t6_w2", c2);
    chk("t6_period_reset", 32'(c2 - c1), 32'd256);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
